// File: rtl/regfile_scbd.sv
// regfile_scbd: MIPS-style register file with hardwired-zero R0, optional
// same-cycle write-through bypass and a per-register busy scoreboard that
// stalls an issuing instruction whose sources still have a pending write.
//
// Issue handshake: issue_vld is the request and stall is the combinational
// inverse of ready. An issue is accepted on a rising edge where
// issue_vld=1 and stall=0. Only an accepted issue with issue_wr=1 marks
// issue_dst busy. A stalled issue has no side effects, and the issuer must
// hold instru and the issue_* fields until the edge where it is accepted.
module regfile_scbd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instru,
  input  logic [ADDR_W-1:0] Rw,
  input  logic [DATA_W-1:0] Di,
  input  logic              WE,
  input  logic              issue_vld,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic              issue_wr,
  output logic [4:0]        Rt,
  output logic [4:0]        Rd,
  output logic [15:0]       imm16,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  output logic              stall,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam bit BYP   = (BYPASS != 0);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic [ADDR_W-1:0] rs_idx;
  logic [ADDR_W-1:0] rt_idx;
  logic              wb_hit_a;
  logic              wb_hit_b;
  logic              clr_a;
  logic              clr_b;
  logic              issue_set;
  logic              unused_opcode;

  // Instruction field decode. Index fields are resized to the register index width.
  assign rs_idx        = ADDR_W'(instru[25:21]);
  assign rt_idx        = ADDR_W'(instru[20:16]);
  assign Rt            = instru[20:16];
  assign Rd            = instru[15:11];
  assign imm16         = instru[15:0];
  assign unused_opcode = ^instru[31:26];

  // A writeback in this cycle that targets a source register. It is used
  // both for forwarding data and for lifting the stall, but only when the
  // bypass is built in.
  assign clr_a    = BYP && WE && (Rw == rs_idx);
  assign clr_b    = BYP && WE && (Rw == rt_idx);
  assign wb_hit_a = clr_a && (rs_idx != '0);
  assign wb_hit_b = clr_b && (rt_idx != '0);

  // Operand A read: R0 is forced to zero, otherwise forward or array.
  always_comb begin
    busA = regs[rs_idx];
    if (rs_idx == '0)  busA = '0;
    else if (wb_hit_a) busA = Di;
  end

  // Operand B read: same structure as operand A, on the rt field.
  always_comb begin
    busB = regs[rt_idx];
    if (rt_idx == '0)  busB = '0;
    else if (wb_hit_b) busB = Di;
  end

  // Stall: a busy source blocks issue unless its producer writes back this
  // cycle and the value can be forwarded. busy[0] is never set, so R0
  // sources never stall.
  always_comb begin
    stall = issue_vld && ((busy[rs_idx] && !clr_a) || (busy[rt_idx] && !clr_b));
  end

  assign issue_set = issue_vld && !stall && issue_wr && (issue_dst != '0);

  // Next scoreboard state. The clear from writeback is applied first, so a
  // new producer issued on the same edge leaves the register busy.
  always_comb begin
    busy_nxt = busy;
    if (WE)        busy_nxt[Rw]        = 1'b0;
    if (issue_set) busy_nxt[issue_dst] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Population count of a scoreboard vector.
  function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + (ADDR_W+1)'(v[i]);
    return c;
  endfunction

  // Scoreboard and its count. The count is taken from the same next-state
  // vector, so it always agrees with busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= popcount(busy_nxt);
    end
  end

  // Register array: synchronous clear, and writes to R0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (WE && (Rw != '0)) begin
      regs[Rw] <= Di;
    end
  end

endmodule
